// File: rtl/flag_write_ctrl.sv
// Write-port arbiter for the hashtable valid-flag register: round-robin insert/delete
// plus an optional clear-all sequencer, built only when FLAG_CTRL_FLUSH_EN is defined.
module flag_write_ctrl #(
   parameter int SIZE = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ins_req,
   input  logic [SIZE-1:0] ins_adr,
   output logic            ins_ack,
   input  logic            del_req,
   input  logic [SIZE-1:0] del_adr,
   output logic            del_ack,
   input  logic            flush_req,
   output logic            flush_busy,
   output logic            flush_done,
   output logic            write_en,
   output logic [SIZE-1:0] write_adr,
   output logic            write_is_valid
);

   localparam logic GRANT_INS = 1'b0;
   localparam logic GRANT_DEL = 1'b1;

`ifdef FLAG_CTRL_FLUSH_EN
   typedef enum logic [1:0] {ARB, FLUSH, DONE} state_t;
`else
   typedef enum logic [1:0] {ARB} state_t;
`endif

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic            write_en_q, write_en_d;
   logic [SIZE-1:0] write_adr_q, write_adr_d;
   logic            write_is_valid_q, write_is_valid_d;
   logic            flush_busy_q, flush_busy_d;
   logic            flush_done_q, flush_done_d;
   logic            grant_ins, grant_del;
   logic            flush_start;

`ifdef FLAG_CTRL_FLUSH_EN
   logic [SIZE-1:0] flush_ptr_q, flush_ptr_d;
   assign flush_start = flush_req;
`else
   logic unused_flush_req;
   assign unused_flush_req = flush_req;
   assign flush_start      = 1'b0;
`endif

   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      write_en_d       = 1'b0;
      write_adr_d      = write_adr_q;
      write_is_valid_d = write_is_valid_q;
      flush_busy_d     = 1'b0;
      flush_done_d     = 1'b0;
      grant_ins        = 1'b0;
      grant_del        = 1'b0;
`ifdef FLAG_CTRL_FLUSH_EN
      flush_ptr_d      = flush_ptr_q;
`endif
      case (state_q)
         ARB: begin
            if (flush_start) begin
`ifdef FLAG_CTRL_FLUSH_EN
               // first clear is issued from here so writes start the cycle after the pulse
               state_d          = FLUSH;
               write_en_d       = 1'b1;
               write_adr_d      = flush_ptr_q;
               write_is_valid_d = 1'b0;
               flush_busy_d     = 1'b1;
               flush_ptr_d      = flush_ptr_q + 1'b1;
`endif
            end else begin
               grant_ins = ins_req && (!del_req || last_grant_q == GRANT_DEL);
               grant_del = del_req && !grant_ins;
               if (grant_ins) begin
                  last_grant_d     = GRANT_INS;
                  write_en_d       = 1'b1;
                  write_adr_d      = ins_adr;
                  write_is_valid_d = 1'b1;
               end else if (grant_del) begin
                  last_grant_d     = GRANT_DEL;
                  write_en_d       = 1'b1;
                  write_adr_d      = del_adr;
                  write_is_valid_d = 1'b0;
               end
            end
         end
`ifdef FLAG_CTRL_FLUSH_EN
         FLUSH: begin
            // pointer back at zero means every address has been cleared
            if (flush_ptr_q == '0) begin
               state_d      = DONE;
               flush_done_d = 1'b1;
            end else begin
               write_en_d       = 1'b1;
               write_adr_d      = flush_ptr_q;
               write_is_valid_d = 1'b0;
               flush_busy_d     = 1'b1;
               flush_ptr_d      = flush_ptr_q + 1'b1;
            end
         end
         DONE: begin
            state_d = ARB;
         end
`endif
         default: begin
            state_d = ARB;
         end
      endcase
      if (reset) begin
         grant_ins = 1'b0;
         grant_del = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ARB;
         last_grant_q     <= GRANT_DEL;
         write_en_q       <= 1'b0;
         write_adr_q      <= '0;
         write_is_valid_q <= 1'b0;
         flush_busy_q     <= 1'b0;
         flush_done_q     <= 1'b0;
`ifdef FLAG_CTRL_FLUSH_EN
         flush_ptr_q      <= '0;
`endif
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         write_en_q       <= write_en_d;
         write_adr_q      <= write_adr_d;
         write_is_valid_q <= write_is_valid_d;
         flush_busy_q     <= flush_busy_d;
         flush_done_q     <= flush_done_d;
`ifdef FLAG_CTRL_FLUSH_EN
         flush_ptr_q      <= flush_ptr_d;
`endif
      end
   end

   assign ins_ack        = grant_ins;
   assign del_ack        = grant_del;
   assign write_en       = write_en_q;
   assign write_adr      = write_adr_q;
   assign write_is_valid = write_is_valid_q;
   assign flush_busy     = flush_busy_q;
   assign flush_done     = flush_done_q;

endmodule

// File: tb/tb_flag_write_ctrl.sv
// Scoreboard bench for flag_write_ctrl; flush scenarios run when FLAG_CTRL_FLUSH_EN is defined.
module tb_flag_write_ctrl;

   localparam int SIZE = 4;
   localparam int NENT = 1 << SIZE;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            ins_req = 1'b0, del_req = 1'b0, flush_req = 1'b0;
   logic [SIZE-1:0] ins_adr = '0, del_adr = '0;
   logic            ins_ack, del_ack, flush_busy, flush_done;
   logic            write_en, write_is_valid;
   logic [SIZE-1:0] write_adr;

   flag_write_ctrl #(.SIZE(SIZE)) dut (
      .clk(clk), .reset(reset),
      .ins_req(ins_req), .ins_adr(ins_adr), .ins_ack(ins_ack),
      .del_req(del_req), .del_adr(del_adr), .del_ack(del_ack),
      .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
      .write_en(write_en), .write_adr(write_adr), .write_is_valid(write_is_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            en;
      logic [SIZE-1:0] adr;
      logic            val;
      logic            busy;
      logic            done;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   logic flags [NENT];

   // behavioural model of the controller
   int              m_st = 0;
   logic            m_last = 1'b1;
   int              m_ptr = 0;
   logic [SIZE-1:0] m_adr = '0;
   logic            m_val = 1'b0;
   logic            e_ia, e_da;

   // monitor: one expected output vector per driven cycle
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         if ({write_en, write_adr, write_is_valid, flush_busy, flush_done} !== mon_e) begin
            failures++;
            $display("FAIL outputs: got en=%b adr=%0d val=%b busy=%b done=%b want en=%b adr=%0d val=%b busy=%b done=%b",
                     write_en, write_adr, write_is_valid, flush_busy, flush_done,
                     mon_e.en, mon_e.adr, mon_e.val, mon_e.busy, mon_e.done);
         end
         if (write_en === 1'b1) flags[write_adr] = write_is_valid;
      end
   end

   task automatic step(input logic rst, input logic ir, input logic [SIZE-1:0] ia,
                       input logic dr, input logic [SIZE-1:0] da, input logic fr);
      exp_t e;
      logic fl;
      @(negedge clk);
      reset = rst; ins_req = ir; ins_adr = ia; del_req = dr; del_adr = da; flush_req = fr;
      #1;
      e = '0; e.adr = m_adr; e.val = m_val;
      e_ia = 1'b0; e_da = 1'b0;
      fl = 1'b0;
`ifdef FLAG_CTRL_FLUSH_EN
      fl = fr;
`endif
      if (rst) begin
         m_st = 0; m_last = 1'b1; m_ptr = 0; m_adr = '0; m_val = 1'b0;
         e = '0;
      end else if (m_st == 0) begin
         if (fl) begin
            e.en = 1'b1; e.adr = SIZE'(m_ptr); e.val = 1'b0; e.busy = 1'b1;
            m_ptr = (m_ptr + 1) % NENT; m_st = 1;
         end else begin
            e_ia = ir && (!dr || m_last);
            e_da = dr && !e_ia;
            if (e_ia) begin e.en = 1'b1; e.adr = ia; e.val = 1'b1; m_last = 1'b0; end
            else if (e_da) begin e.en = 1'b1; e.adr = da; e.val = 1'b0; m_last = 1'b1; end
         end
      end else if (m_st == 1) begin
         if (m_ptr == 0) begin
            e.done = 1'b1; m_st = 2;
         end else begin
            e.en = 1'b1; e.adr = SIZE'(m_ptr); e.val = 1'b0; e.busy = 1'b1;
            m_ptr = (m_ptr + 1) % NENT;
         end
      end else begin
         m_st = 0;
      end
      m_adr = e.adr; m_val = e.val;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 4'd5, 1'b1, 4'd6, 1'b0);
         checks++;
         if (ins_ack !== 1'b0 || del_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_acks: got ins=%b del=%b want 0 0", ins_ack, del_ack);
         end
      end
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      checks++;
      if ({write_en, write_adr, write_is_valid, flush_busy, flush_done, ins_ack, del_ack} !== '0) begin
         failures++;
         $display("FAIL reset_idle: got en=%b adr=%0d val=%b busy=%b done=%b ia=%b da=%b want all 0",
                  write_en, write_adr, write_is_valid, flush_busy, flush_done, ins_ack, del_ack);
      end
   endtask

   task automatic test_single_insert();
      step(1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
      checks++;
      if (ins_ack !== 1'b1 || del_ack !== 1'b0) begin
         failures++;
         $display("FAIL single_insert_ack: got ins=%b del=%b want 1 0", ins_ack, del_ack);
      end
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (write_en !== 1'b1 || write_adr !== 4'd5 || write_is_valid !== 1'b1) begin
         failures++;
         $display("FAIL single_insert_write: got en=%b adr=%0d val=%b want 1 5 1", write_en, write_adr, write_is_valid);
      end
   endtask

   task automatic test_contention();
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 4'd3, 1'b1, 4'd7, 1'b0);
         checks++;
         if (ins_ack !== (i % 2 == 0) || del_ack !== (i % 2 == 1)) begin
            failures++;
            $display("FAIL contention_ack[%0d]: got ins=%b del=%b want %b %b", i, ins_ack, del_ack,
                     i % 2 == 0, i % 2 == 1);
         end
      end
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_same_addr();
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b1, 4'd9, 1'b1, 4'd9, 1'b0);
      checks++;
      if (ins_ack !== 1'b1 || del_ack !== 1'b0) begin
         failures++;
         $display("FAIL same_addr_first: got ins=%b del=%b want 1 0", ins_ack, del_ack);
      end
      step(1'b0, 1'b0, 4'd9, 1'b1, 4'd9, 1'b0);
      checks++;
      if (ins_ack !== 1'b0 || del_ack !== 1'b1) begin
         failures++;
         $display("FAIL same_addr_second: got ins=%b del=%b want 0 1", ins_ack, del_ack);
      end
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (flags[9] !== 1'b0) begin
         failures++;
         $display("FAIL same_addr_flag: got flag9=%b want 0", flags[9]);
      end
   endtask

   task automatic test_hold_and_idle();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 4'd0, 1'b1, 4'd12, 1'b0);
         checks++;
         if (del_ack !== 1'b1 || ins_ack !== 1'b0) begin
            failures++;
            $display("FAIL hold_del[%0d]: got ins=%b del=%b want 0 1", i, ins_ack, del_ack);
         end
      end
      step(1'b0, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0);
      step(1'b0, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0);
      checks++;
      if (write_en !== 1'b0 || write_adr !== 4'd12 || write_is_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_hold: got en=%b adr=%0d val=%b want 0 12 0", write_en, write_adr, write_is_valid);
      end
   endtask

`ifdef FLAG_CTRL_FLUSH_EN
   task automatic test_flush();
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
      checks++;
      if (ins_ack !== 1'b0) begin
         failures++;
         $display("FAIL flush_start_ack: got ins=%b want 0", ins_ack);
      end
      for (int i = 1; i <= NENT + 2; i++) begin
         step(1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
         checks++;
         if (ins_ack !== (i == NENT + 2) || flush_busy !== (i <= NENT) || flush_done !== (i == NENT + 1)) begin
            failures++;
            $display("FAIL flush_cycle[%0d]: got ack=%b busy=%b done=%b want %b %b %b", i, ins_ack,
                     flush_busy, flush_done, i == NENT + 2, i <= NENT, i == NENT + 1);
         end
      end
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_flush_reset();
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (flush_busy !== 1'b0 || write_en !== 1'b0) begin
         failures++;
         $display("FAIL flush_abort: got busy=%b en=%b want 0 0", flush_busy, write_en);
      end
      for (int i = 0; i < NENT + 2; i++) begin
         step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
         checks++;
         if (flush_done !== 1'b0) begin
            failures++;
            $display("FAIL flush_abort_done[%0d]: got done=%b want 0", i, flush_done);
         end
      end
      step(1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
      checks++;
      if (ins_ack !== 1'b1) begin
         failures++;
         $display("FAIL flush_abort_insert: got ins=%b want 1", ins_ack);
      end
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask
`else
   task automatic test_flush_ignored();
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
      checks++;
      if (del_ack !== 1'b1) begin
         failures++;
         $display("FAIL flush_ignored_ack: got del=%b want 1", del_ack);
      end
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (write_en !== 1'b1 || write_adr !== 4'd2 || write_is_valid !== 1'b0 || flush_busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_ignored_write: got en=%b adr=%0d val=%b busy=%b want 1 2 0 0",
                  write_en, write_adr, write_is_valid, flush_busy);
      end
   endtask
`endif

   task automatic test_random();
      logic ir, dr, fr;
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 80; i++) begin
         ir = 1'($urandom_range(0, 1));
         dr = 1'($urandom_range(0, 1));
         fr = ($urandom_range(0, 39) == 0);
         step(1'b0, ir, SIZE'($urandom_range(0, NENT - 1)), dr, SIZE'($urandom_range(0, NENT - 1)), fr);
         checks++;
         if (ins_ack !== e_ia || del_ack !== e_da) begin
            failures++;
            $display("FAIL random_ack[%0d]: got ins=%b del=%b want %b %b", i, ins_ack, del_ack, e_ia, e_da);
         end
      end
      for (int i = 0; i < NENT + 3; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < NENT; i++) flags[i] = 1'bx;
      test_reset();
      test_single_insert();
      test_contention();
      test_same_addr();
      test_hold_and_idle();
`ifdef FLAG_CTRL_FLUSH_EN
      test_flush();
      test_flush_reset();
`else
      test_flush_ignored();
`endif
      test_random();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
